// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller states and the fixed iteration constants.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam logic [31:0] DIV0_QUOT  = 32'hFFFFFFFF;
    localparam int          STEP_COUNT = 32;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit. Operands are converted to unsigned
// magnitudes at start, one radix-2 step runs per cycle on a single 2*DATA_W
// accumulator/remainder register through one shared adder, and the sign
// correction is applied in a final FIX cycle that writes HI/LO.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              mthi,
    input  logic              mtlo,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    counter;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_step;
    logic [DATA_W-1:0]   divisor_mag;
    logic [DATA_W-1:0]   dividend_raw;
    logic                is_div;
    logic                div_zero;
    logic                neg_result;
    logic                neg_rem;

    logic                signed_in;
    logic                div_in;
    logic                sign_a_in;
    logic                sign_b_in;
    logic [DATA_W-1:0]   mag_a_in;
    logic [DATA_W-1:0]   mag_b_in;

    logic [DATA_W:0]     add_a;
    logic [DATA_W:0]     add_b;
    logic                add_cin;
    logic [DATA_W:0]     add_sum;
    logic                add_cout;

    logic [2*DATA_W-1:0] prod_fixed;
    logic [DATA_W-1:0]   quot_fixed;
    logic [DATA_W-1:0]   rem_fixed;

    // Controller state register; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE waits for start, CALC runs the fixed step count, FIX lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (counter == CNT_W'(STEP_COUNT - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode the incoming op and strip signs so the iteration only ever sees magnitudes.
    always_comb begin
        signed_in = (op == OP_MULT) || (op == OP_DIV);
        div_in    = (op == OP_DIV)  || (op == OP_DIVU);
        sign_a_in = signed_in & rs_data[DATA_W-1];
        sign_b_in = signed_in & rt_data[DATA_W-1];
        mag_a_in  = sign_a_in ? -rs_data : rs_data;
        mag_b_in  = sign_b_in ? -rt_data : rt_data;
    end

    // Shared adder: multiply adds the multiplicand into the upper half when the
    // low bit is set; divide subtracts the divisor from the left-shifted remainder.
    always_comb begin
        if (is_div) begin
            add_a   = acc[2*DATA_W-1:DATA_W-1];
            add_b   = ~{1'b0, divisor_mag};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc[2*DATA_W-1:DATA_W]};
            add_b   = acc[0] ? {1'b0, divisor_mag} : '0;
            add_cin = 1'b0;
        end
        {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{(DATA_W+1){1'b0}}, add_cin};
    end

    // One radix-2 step: shift-right with carry for multiply, restoring shift-left for divide.
    always_comb begin
        if (is_div) begin
            if (add_cout) begin
                acc_step = {add_sum[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            end else begin
                acc_step = {acc[2*DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_step = {add_sum, acc[DATA_W-1:1]};
        end
    end

    // Sign correction of the unsigned result before it is committed to HI/LO.
    always_comb begin
        prod_fixed = neg_result ? -acc : acc;
        quot_fixed = neg_result ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        rem_fixed  = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    end

    // Datapath and architectural HI/LO: latch operands on start, iterate, commit in FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter      <= '0;
            acc          <= '0;
            divisor_mag  <= '0;
            dividend_raw <= '0;
            is_div       <= 1'b0;
            div_zero     <= 1'b0;
            neg_result   <= 1'b0;
            neg_rem      <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc          <= {{DATA_W{1'b0}}, mag_a_in};
                        divisor_mag  <= mag_b_in;
                        dividend_raw <= rs_data;
                        is_div       <= div_in;
                        div_zero     <= div_in && (rt_data == '0);
                        neg_result   <= sign_a_in ^ sign_b_in;
                        neg_rem      <= sign_a_in;
                        counter      <= '0;
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                CALC: begin
                    acc     <= acc_step;
                    counter <= counter + CNT_W'(1);
                end
                FIX: begin
                    if (is_div) begin
                        if (div_zero) begin
                            lo <= DIV0_QUOT;
                            hi <= dividend_raw;
                        end else begin
                            lo <= quot_fixed;
                            hi <= rem_fixed;
                        end
                    end else begin
                        {hi, lo} <= prod_fixed;
                    end
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a cycle-level behavioural model
// (latency countdown plus plain arithmetic results) is compared against the
// DUT on every cycle, with directed literal expectations and random traffic.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks      = 0;
    int failures    = 0;
    int fail_prints = 0;
    bit cmp_en      = 1'b0;

    int          m_cnt     = 0;
    logic [31:0] m_hi      = '0;
    logic [31:0] m_lo      = '0;
    logic [31:0] m_pend_hi = '0;
    logic [31:0] m_pend_lo = '0;
    logic        m_done    = 1'b0;

    muldiv_unit #(.DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Architectural result {hi,lo} of one operation, straight from the arithmetic rules.
    function automatic logic [63:0] modelResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  p = 64'(sa * sb);
            OP_MULTU: p = 64'(a) * 64'(b);
            OP_DIV: begin
                if (b == 32'h0) begin
                    p = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) p = {a, 32'hFFFFFFFF};
                else            p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Operand generator biased toward the interesting corner values.
    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'h80000000;
            2:       v = 32'hFFFFFFFF;
            3:       v = 32'h1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // Drive one cycle of inputs from a negedge; the command strobes drop afterwards.
    task automatic applyStimulus(input logic st, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic mh, input logic ml);
        start   = st;
        op      = o;
        rs_data = a;
        rt_data = b;
        mthi    = mh;
        mtlo    = ml;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
    endtask

    task automatic waitDone(input string name);
        for (int k = 0; k < 60 && done !== 1'b1; k++) @(negedge clk);
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: done=%b, expected 1 within 60 cycles", name, done);
        end
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        applyStimulus(1'b1, o, a, b, 1'b0, 1'b0);
        waitDone(name);
        checkOutput({name, "_hi"}, hi, exp_hi);
        checkOutput({name, "_lo"}, lo, exp_lo);
        checkOutput({name, "_model_hi"}, m_hi, exp_hi);
        checkOutput({name, "_model_lo"}, m_lo, exp_lo);
        @(negedge clk);
    endtask

    // Reference model: idle when no latency is pending, result lands 33 edges after start.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    {m_pend_hi, m_pend_lo} <= modelResult(op, rs_data, rt_data);
                    m_cnt <= 33;
                end else begin
                    if (mthi) m_hi <= rs_data;
                    if (mtlo) m_lo <= rs_data;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_pend_hi;
                    m_lo   <= m_pend_lo;
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cyc_busy", 32'(busy), 32'(m_cnt != 0));
            checkOutput("cyc_done", 32'(done), 32'(m_done));
            checkOutput("cyc_hi", hi, m_hi);
            checkOutput("cyc_lo", lo, m_lo);
        end
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] global timeout");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int          n;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = '0;
        rt_data = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        cmp_en = 1'b1;

        $display("[TB] unsigned max product and latency");
        applyStimulus(1'b1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("t1_busy_cycles", 32'(n), 32'd33);
        checkOutput("t1_done", 32'(done), 32'h1);
        checkOutput("t1_hi", hi, 32'hFFFFFFFE);
        checkOutput("t1_lo", lo, 32'h00000001);
        @(negedge clk);
        checkOutput("t1_done_once", 32'(done), 32'h0);

        $display("[TB] signed multiply and divide");
        runOp("t2_mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        runOp("t2_mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        runOp("t3_div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("t3_div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
        runOp("t3_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        runOp("t4_div0", OP_DIV, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF);
        runOp("t4_div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        $display("[TB] commands while busy, back-to-back start, mid-op reset");
        applyStimulus(1'b1, OP_MULTU, 32'h12345, 32'h100, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, OP_DIVU, 32'd9, 32'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, OP_MULT, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        waitDone("t5_ignore");
        checkOutput("t5_ignore_hi", hi, 32'h0);
        checkOutput("t5_ignore_lo", lo, 32'h01234500);
        applyStimulus(1'b1, OP_MULTU, 32'd3, 32'd4, 1'b0, 1'b0);
        waitDone("t5_b2b");
        checkOutput("t5_b2b_hi", hi, 32'h0);
        checkOutput("t5_b2b_lo", lo, 32'd12);
        @(negedge clk);
        applyStimulus(1'b1, OP_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t5_rst_busy", 32'(busy), 32'h0);
        checkOutput("t5_rst_hi", hi, 32'h0);
        checkOutput("t5_rst_lo", lo, 32'h0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        checkOutput("t5_rst_no_done", 32'(n), 32'h0);

        $display("[TB] idle moves and start priority");
        applyStimulus(1'b0, OP_MULT, 32'h55, 32'h0, 1'b0, 1'b1);
        checkOutput("t6_mtlo_lo", lo, 32'h55);
        applyStimulus(1'b0, OP_MULT, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        checkOutput("t6_mthi_hi", hi, 32'hDEADBEEF);
        checkOutput("t6_mthi_lo", lo, 32'h55);
        applyStimulus(1'b0, OP_MULT, 32'hA5A5, 32'h0, 1'b1, 1'b1);
        checkOutput("t6_both_hi", hi, 32'hA5A5);
        checkOutput("t6_both_lo", lo, 32'hA5A5);
        applyStimulus(1'b1, OP_MULTU, 32'd2, 32'd3, 1'b0, 1'b1);
        checkOutput("t6_drop_lo", lo, 32'hA5A5);
        waitDone("t6_mul");
        checkOutput("t6_mul_hi", hi, 32'h0);
        checkOutput("t6_mul_lo", lo, 32'd6);
        @(negedge clk);

        $display("[TB] random traffic");
        for (int it = 0; it < 40; it++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pickOperand();
            rb = pickOperand();
            applyStimulus(1'b1, ro, ra, rb, 1'($urandom), 1'($urandom));
            for (int k = 0; k < 60 && done !== 1'b1; k++) begin
                start   = 1'($urandom);
                mthi    = 1'($urandom);
                mtlo    = 1'($urandom);
                op      = 2'($urandom);
                rs_data = $urandom;
                rt_data = $urandom;
                @(negedge clk);
            end
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
            if (done !== 1'b1) begin
                checks++;
                failures++;
                $display("[TB] FAIL rand_timeout: done=%b, expected 1 within 60 cycles", done);
            end
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(1'b0, OP_MULT, $urandom, 32'h0, 1'($urandom), 1'($urandom));
            end
        end
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative HI/LO multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file and consumes the two read ports (rs on data1, rt on data2) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It holds the architectural HI/LO registers and raises busy so the pipeline control can stall MFHI/MFLO and further mul/div issue until results are ready.

Parameters:
DATA_W, 32, operand and HI/LO width; the counter width is derived as clog2(DATA_W).

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  issue the operation on op; sampled only while idle
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data  input  DATA_W  operand A / dividend, from register-file read port 1
rt_data  input  DATA_W  operand B / divisor, from register-file read port 2
mthi  input  1  write rs_data to HI
mtlo  input  1  write rs_data to LO
busy  output  1  operation in progress
done  output  1  one-cycle pulse in the cycle HI/LO first show a new result
hi  output  DATA_W  architectural HI
lo  output  DATA_W  architectural LO

Behaviour:
- Reset (synchronous, clk edge with reset=1): state IDLE, hi=lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation with no partial write.
- States:
  - IDLE: on start, latch operand magnitudes, sign flags, op and divide-by-zero flag; go to CALC with counter=0.
  - CALC: one radix-2 step per cycle (shift-add multiply, restoring divide on unsigned magnitudes). 32 cycles; counter 0..31, then go to FIX.
  - FIX: apply sign correction, write hi/lo, go to IDLE.
- busy = 1 in CALC and FIX; busy is a registered output.
- Latency: start sampled at edge E0; busy high for the 33 cycles after E0; hi/lo hold the new value and done=1 after edge E33; busy=0 in that same cycle.
- Arithmetic results:
  - MULT/MULTU: {hi,lo} = the full 64-bit product, signed or unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (rt_data=0, DIV or DIVU): lo=0xFFFFFFFF, hi=rs_data as sampled at start.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No exception is raised.
- hi/lo are stable throughout CALC; the old values stay visible until the FIX edge.
- mthi/mtlo while IDLE: the register takes rs_data at the next edge. Both asserted together: both registers are written.
- start together with mthi/mtlo while IDLE: start wins and the move is dropped.
- start, mthi and mtlo while busy are ignored. The stall logic must prevent this; the unit does not queue commands.
- A start in the same cycle that done=1 is accepted, since the unit is IDLE in that cycle.
- Operands are sampled only at start; later changes on rs_data/rt_data have no effect.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, CALC, FIX);
  - the constants DIV0_QUOT=32'hFFFFFFFF and the step count of 32.
- No sub-module. It is a single module of about 200 lines: the datapath is one 64-bit accumulator/remainder shift register plus an adder shared by multiply and divide.

Test Plan:
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy high for exactly 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
2. MULT 0xFFFFFFFD (-3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1; DIVU 100/7 -> lo=14, hi=2.
4. DIV 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. During CALC: start (DIVU 9/3) and mthi 0xDEADBEEF are ignored and the original result lands. A second start in the done cycle is accepted. reset asserted at CALC cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse.
6. Idle mthi 0xDEADBEEF -> hi=0xDEADBEEF next cycle, lo unchanged. start MULTU 2×3 with mtlo in the same cycle -> mtlo dropped; hi=0, lo=6 after 33 cycles.
